// File: rtl/lut_config_chain_pkg.sv
// Shared types and size helpers for the LUT configuration chain.
package lut_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_t;

    function automatic int calc_total(input int num_luts, input int addr_bits);
        return num_luts * (1 << addr_bits);
    endfunction

    function automatic int calc_words(input int num_luts, input int addr_bits, input int chain_width);
        return calc_total(num_luts, addr_bits) / chain_width;
    endfunction

endpackage

// File: rtl/lut_config_chain_if.sv
// Configuration stream handshake plus commit/readback status.
interface lut_config_chain_if #(
    parameter int CHAIN_WIDTH = 1
);
    logic                   cfg_start;
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [CHAIN_WIDTH-1:0] cfg_data;
    logic                   cfg_done;
    logic                   cfg_loaded;
    logic [CHAIN_WIDTH-1:0] rb_data;

    modport master (
        output cfg_start, cfg_valid, cfg_data,
        input  cfg_ready, cfg_done, cfg_loaded, rb_data
    );

    modport slave (
        input  cfg_start, cfg_valid, cfg_data,
        output cfg_ready, cfg_done, cfg_loaded, rb_data
    );
endinterface

// File: rtl/lut_read_mux.sv
// Single-channel combinational LUT read: selects one of MEM_SIZE config bits.
module lut_read_mux #(
    parameter int ADDR_BITS = 4,
    parameter int MEM_SIZE  = 2**ADDR_BITS
) (
    input  logic [MEM_SIZE-1:0]  lut,
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 out
);
    assign out = lut[addr];
endmodule

// File: rtl/lut_config_chain.sv
// Double-buffered multi-channel LUT config store: stream into shadow, commit atomically.
// Optional readback of the previous configuration via macro CONFIG_READBACK_EN.
module lut_config_chain
    import lut_cfg_pkg::*;
#(
    parameter int ADDR_BITS   = 4,
    parameter int MEM_SIZE    = 2**ADDR_BITS,
    parameter int NUM_LUTS    = 2,
    parameter int CHAIN_WIDTH = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    lut_config_chain_if.slave             cfg,
    input  logic [NUM_LUTS*ADDR_BITS-1:0] addr,
    output logic [NUM_LUTS-1:0]           out
);
    localparam int TOTAL = calc_total(NUM_LUTS, ADDR_BITS);
    localparam int WORDS = calc_words(NUM_LUTS, ADDR_BITS, CHAIN_WIDTH);
    localparam int CNT_W = $clog2(WORDS + 1);

    if (TOTAL % CHAIN_WIDTH != 0) begin : g_bad_chain_width
        $error("lut_config_chain: NUM_LUTS*MEM_SIZE must be divisible by CHAIN_WIDTH");
    end
    if (MEM_SIZE != (1 << ADDR_BITS)) begin : g_bad_mem_size
        $error("lut_config_chain: MEM_SIZE must equal 2**ADDR_BITS");
    end

    cfg_state_t       state_reg, state_next;
    logic [TOTAL-1:0] shadow_reg;
    logic [TOTAL-1:0] active_reg;
    logic [TOTAL-1:0] shadow_shift;
    logic [CNT_W-1:0] cnt_reg;
    logic             loaded_reg;
    logic             ready_int;
    logic             done_int;
    logic             accept;
    logic             restart;
    logic             last_word;

    // A start is honoured in IDLE and LOAD only; COMMIT always completes.
    assign restart   = cfg.cfg_start && (state_reg != COMMIT);
    assign accept    = cfg.cfg_valid && ready_int;
    assign last_word = (cnt_reg == CNT_W'(WORDS - 1));

    if (WORDS == 1) begin : g_shift_single
        assign shadow_shift = cfg.cfg_data;
    end else begin : g_shift_chain
        assign shadow_shift = {cfg.cfg_data, shadow_reg[TOTAL-1:CHAIN_WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cfg.cfg_start) state_next = LOAD;
            LOAD:    if (!cfg.cfg_start && accept && last_word) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready_int = 1'b0;
        done_int  = 1'b0;
        case (state_reg)
            LOAD:    ready_int = 1'b1;
            COMMIT:  done_int  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_reg <= '0;
            active_reg <= '0;
            cnt_reg    <= '0;
            loaded_reg <= 1'b0;
        end else if (restart) begin
            cnt_reg <= '0;
`ifdef CONFIG_READBACK_EN
            shadow_reg <= active_reg;
`endif
        end else if (state_reg == COMMIT) begin
            active_reg <= shadow_reg;
            loaded_reg <= 1'b1;
        end else if (accept) begin
            shadow_reg <= shadow_shift;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end
    end

    assign cfg.cfg_ready  = ready_int;
    assign cfg.cfg_done   = done_int;
    assign cfg.cfg_loaded = loaded_reg;

`ifdef CONFIG_READBACK_EN
    // Old configuration drains out of the low end as the new one fills the top.
    assign cfg.rb_data = shadow_reg[CHAIN_WIDTH-1:0];
`else
    assign cfg.rb_data = '0;
`endif

    for (genvar gi = 0; gi < NUM_LUTS; gi++) begin : g_chan
        lut_read_mux #(
            .ADDR_BITS (ADDR_BITS),
            .MEM_SIZE  (MEM_SIZE)
        ) u_read_mux (
            .lut  (active_reg[gi*MEM_SIZE +: MEM_SIZE]),
            .addr (addr[gi*ADDR_BITS +: ADDR_BITS]),
            .out  (out[gi])
        );
    end

endmodule

// File: doc/lut_config_chain.md
# lut_config_chain

Multi-channel, double-buffered LUT configuration store for the SLICEL fabric. Configuration arrives as a valid/ready word stream into a shadow shift chain. It is committed atomically to the active latches only after a complete bitstream has been received, so the LUT outputs never see a partially loaded configuration. Each channel is an independent 2^ADDR_BITS-entry LUT with a combinational read, and it replaces the single-LUT, whole-word block-set configuration store.

## Interface

Parameters:
- ADDR_BITS, 4, LUT input count per channel.
- MEM_SIZE, 2**ADDR_BITS, entries per channel (derived; do not override).
- NUM_LUTS, 2, number of LUT channels.
- CHAIN_WIDTH, 1, configuration bits accepted per handshake.
  - TOTAL = NUM_LUTS*MEM_SIZE must be divisible by CHAIN_WIDTH.
  - Elaboration fails otherwise.
- WORDS, TOTAL/CHAIN_WIDTH, words per bitstream (derived).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset: asynchronous assert, active-low.
- cfg_start  in  1  one-cycle request to begin (or restart) a load.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  block accepts a word this cycle.
- cfg_data  in  CHAIN_WIDTH  configuration word.
- cfg_done  out  1  high for exactly one cycle while committing.
- cfg_loaded  out  1  at least one commit has happened since reset.
- addr  in  NUM_LUTS*ADDR_BITS  channel i address is addr[i*ADDR_BITS +: ADDR_BITS].
- out  out  NUM_LUTS  out[i] = active[i*MEM_SIZE + addr_i].
- rb_data  out  CHAIN_WIDTH  readback word (see Configuration).

## Operation

State machine states: IDLE, LOAD, COMMIT.

- **Reset (rst_n low):**
  - Applies immediately, regardless of clk.
  - State goes to IDLE.
  - Active store, shadow and word counter are cleared to 0.
  - cfg_ready=0, cfg_done=0, cfg_loaded=0, out=0, rb_data=0.
  - Reset asserted mid-load discards the partial stream. No commit occurs.
- **IDLE:**
  - cfg_ready=0.
  - cfg_start moves to LOAD and clears the counter.
- **LOAD:**
  - cfg_ready=1.
  - An accept is cfg_valid & cfg_ready.
  - On each accept: shadow <= {cfg_data, shadow[TOTAL-1:CHAIN_WIDTH]} and the counter increments.
  - The first word received ends in shadow[CHAIN_WIDTH-1:0] (LSB-first stream).
  - The accept that makes the count equal WORDS moves to COMMIT.
  - cfg_start in LOAD restarts the load: counter goes to 0, the word on cfg_data that cycle is dropped, and the state stays LOAD.
  - cfg_valid low means no state change.
- **COMMIT:**
  - cfg_ready=0, cfg_done=1.
  - At the end of the cycle: active <= shadow, cfg_loaded <= 1, state goes to IDLE.
  - cfg_start during COMMIT is ignored.
- **LUT read:**
  - Purely combinational from the active store and addr.
  - Unaffected by LOAD activity.

## Timing

- Load latency: an uninterrupted stream (valid held high) takes WORDS cycles in LOAD, then 1 COMMIT cycle.
- out reflects the new configuration from the cycle after cfg_done.
- cfg_done is a Moore output (state==COMMIT). It has no combinational path from inputs.
- cfg_ready depends only on state. It is independent of cfg_valid and carries no combinational loop.
- Back-to-back loads: cfg_start can be taken in the IDLE cycle that immediately follows COMMIT.
- Counter width is $clog2(WORDS+1). It never wraps, because it is cleared on every start.

## Configuration

CONFIG_READBACK_EN:

- **Defined:**
  - On cfg_start, shadow <= active. This overrides the shift for that cycle.
  - rb_data = shadow[CHAIN_WIDTH-1:0], so during LOAD the previous configuration shifts out word-for-word as the new one shifts in.
  - The first readback word is valid in the first LOAD cycle.
- **Undefined:**
  - The shadow is not preloaded on start.
  - rb_data is tied to 0.
  - No readback logic is synthesised.

## Structure

- Shared package lut_cfg_pkg:
  - State enum {IDLE, LOAD, COMMIT}.
  - Function computing TOTAL and WORDS.
- One sub-module: lut_read_mux. It is a single-channel MEM_SIZE:1 read mux, instantiated NUM_LUTS times by generate.
- Shadow, active, counter and FSM live in the top module.

## Test plan

Use NUM_LUTS=2, ADDR_BITS=4, CHAIN_WIDTH=4 (WORDS=8) unless stated.

1. **Reset:** rst_n low mid-cycle -> out=0, cfg_ready=0, cfg_loaded=0 immediately, without waiting for a clk edge.
2. **Full load:** start, then words 0x1,0x2,…,0x8 with valid held high.
   - cfg_done pulses in the 9th cycle after start.
   - Active becomes 0x87654321: channel 0 = 0x4321, channel 1 = 0x8765.
   - addr0=0 -> out[0]=1; addr0=1 -> out[0]=0; addr1=15 -> out[1]=1.
3. **Stalled stream:** same words with valid low every other cycle -> identical final config; cfg_done 16 cycles after start.
4. **Restart:** start, 3 words, start again, then 8 words 0xF -> active=0xFFFFFFFF; exactly one cfg_done.
5. **Reset mid-load:** after 5 words, pulse rst_n low -> active stays 0, no cfg_done, state IDLE.
6. **Readback (CONFIG_READBACK_EN):** after test 2, load 8 words 0x0 -> rb_data sequence 0x1,0x2,…,0x8 on the accept cycles; final active=0.
